nco_sweep_ctrl: RTL

Frequency-sweep sequencer that programs the phase_step input of the 32-bit down-counting NCO. It steps phase_step from a start value toward a stop value in fixed increments. Each value is held for a programmable dwell time. Single, repeat and triangle (up/down) sweep modes are supported. It sits between the control/switch logic and the NCO, replacing a static phase_step register.

---
 rtl/nco_pkg.sv | 29 ++
 rtl/dwell_timer.sv | 55 +++++
 rtl/nco_sweep_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nco_pkg
// Purpose  : Shared definitions for the NCO frequency-sweep sequencer:
//            default widths, sweep-mode encoding and sequencer state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nco_pkg;

  localparam int DEF_STEP_W  = 32;
  localparam int DEF_DWELL_W = 16;

  // Mode 3 is reserved and is handled exactly like single.
  typedef enum logic [1:0] {
    SWEEP_SINGLE = 2'd0,
    SWEEP_REPEAT = 2'd1,
    SWEEP_TRI    = 2'd2,
    SWEEP_RSVD   = 2'd3
  } sweep_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DWELL  = 2'd1,
    ST_FINISH = 2'd2
  } sweep_state_e;

endpackage : nco_pkg
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : dwell_timer
// Purpose  : Down-counter that times how long each phase_step value is held.
//            A dwell value of 0 is treated as 1.
// Ports    : clk       - clock
//            rst       - synchronous active-high reset
//            load      - (re)load counter with dwell_val
//            run       - counting enabled (sequencer in DWELL)
//            dwell_val - hold time in cycles
//            expire    - high in the last cycle of the current hold
// Revision : 1.0 - initial release
// ============================================================================
module dwell_timer
  import nco_pkg::*;
#(
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell_val,
  output logic               expire
);

  localparam logic [DWELL_W-1:0] C_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic [DWELL_W-1:0] load_val;

  always_comb begin
    load_val = (dwell_val == '0) ? C_ONE : dwell_val;
    // The counter holds the number of cycles still to show, including the
    // current one, so the value is on its last cycle when the count is 1.
    expire   = run && (cnt_q <= C_ONE);
    cnt_d    = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (run && !expire) begin
      cnt_d = cnt_q - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : dwell_timer
`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nco_sweep_ctrl
// Purpose  : Frequency-sweep sequencer driving the NCO phase_step input.
//            Steps from a start value toward a stop value in fixed increments,
//            holding each value for a programmable dwell. Single, repeat and
//            triangle modes.
// Ports    : sys_clk, sys_rst       - clock, synchronous active-high reset
//            start, abort           - sweep control
//            cfg_start/stop/inc     - sweep endpoints and step magnitude
//            cfg_dwell, cfg_mode    - hold time per value, sweep mode
//            phase_step, step_upd   - NCO step value and its change strobe
//            busy, done, sweep_dir  - status
// Revision : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int STEP_W  = DEF_STEP_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [STEP_W-1:0]  cfg_start,
  input  logic [STEP_W-1:0]  cfg_stop,
  input  logic [STEP_W-1:0]  cfg_inc,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  output logic [STEP_W-1:0]  phase_step,
  output logic               step_upd,
  output logic               busy,
  output logic               done,
  output logic               sweep_dir
);

  sweep_state_e       state_q,    state_d;
  sweep_mode_e        mode_q,     mode_d;
  logic [STEP_W-1:0]  ps_q,       ps_d;
  logic [STEP_W-1:0]  start_q,    start_d;
  logic [STEP_W-1:0]  stop_q,     stop_d;
  logic [STEP_W-1:0]  inc_q,      inc_d;
  logic [STEP_W-1:0]  target_q,   target_d;
  logic [DWELL_W-1:0] dwell_q,    dwell_d;
  logic               dir_q,      dir_d;
  logic               step_upd_q, step_upd_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;

  logic               accept;
  logic               end_of_leg;
  logic               flip;
  logic               step_up;
  logic [STEP_W-1:0]  swap_target;
  logic [STEP_W-1:0]  step_target;
  logic [STEP_W:0]    sum;
  logic [STEP_W:0]    diff;
  logic [STEP_W-1:0]  step_val;

  logic               timer_load;
  logic               timer_run;
  logic [DWELL_W-1:0] timer_val;
  logic               timer_expire;

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .load      (timer_load),
    .run       (timer_run),
    .dwell_val (timer_val),
    .expire    (timer_expire)
  );

  // Next-value datapath. A leg ends once the target has been shown for a
  // full dwell; a zero increment can never move, so it ends immediately.
  // In triangle mode the leg turnaround steps straight away in the new
  // direction so the endpoint is not shown twice.
  always_comb begin
    accept      = (state_q == ST_IDLE) && start && !abort;
    end_of_leg  = (ps_q == target_q) || (inc_q == '0);
    flip        = end_of_leg && (mode_q == SWEEP_TRI);
    step_up     = dir_q ^ flip;
    swap_target = (target_q == stop_q) ? start_q : stop_q;
    step_target = flip ? swap_target : target_q;
    sum         = {1'b0, ps_q} + {1'b0, inc_q};
    diff        = {1'b0, ps_q} - {1'b0, inc_q};
    if (step_up) begin
      step_val = (sum[STEP_W] || (sum[STEP_W-1:0] >= step_target))
               ? step_target : sum[STEP_W-1:0];
    end else begin
      step_val = (diff[STEP_W] || (diff[STEP_W-1:0] <= step_target))
               ? step_target : diff[STEP_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    ps_d       = ps_q;
    start_d    = start_q;
    stop_d     = stop_q;
    inc_d      = inc_q;
    target_d   = target_q;
    dwell_d    = dwell_q;
    dir_d      = dir_q;
    step_upd_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timer_load = 1'b0;
    timer_run  = (state_q == ST_DWELL);
    timer_val  = accept ? cfg_dwell : dwell_q;

    case (state_q)
      ST_IDLE: begin
        dir_d = 1'b0;
        if (accept) begin
          start_d    = cfg_start;
          stop_d     = cfg_stop;
          inc_d      = cfg_inc;
          dwell_d    = cfg_dwell;
          mode_d     = sweep_mode_e'(cfg_mode);
          target_d   = cfg_stop;
          dir_d      = (cfg_start <= cfg_stop);
          ps_d       = cfg_start;
          step_upd_d = 1'b1;
          busy_d     = 1'b1;
          timer_load = 1'b1;
          state_d    = ST_DWELL;
        end
      end

      ST_DWELL: begin
        if (abort) begin
          state_d    = ST_IDLE;
          ps_d       = '0;
          step_upd_d = 1'b1;
          busy_d     = 1'b0;
          dir_d      = 1'b0;
        end else if (timer_expire) begin
          if (end_of_leg && (mode_q == SWEEP_REPEAT)) begin
            ps_d       = start_q;
            step_upd_d = 1'b1;
            timer_load = 1'b1;
          end else if (end_of_leg && (mode_q != SWEEP_TRI)) begin
            // single and reserved modes: keep the final value on the NCO
            state_d = ST_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            if (flip) begin
              dir_d    = ~dir_q;
              target_d = swap_target;
            end
            ps_d       = step_val;
            step_upd_d = 1'b1;
            timer_load = 1'b1;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
        dir_d   = 1'b0;
        if (abort) begin
          ps_d       = '0;
          step_upd_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        dir_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= SWEEP_SINGLE;
      ps_q       <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      inc_q      <= '0;
      target_q   <= '0;
      dwell_q    <= '0;
      dir_q      <= 1'b0;
      step_upd_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      ps_q       <= ps_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      inc_q      <= inc_d;
      target_q   <= target_d;
      dwell_q    <= dwell_d;
      dir_q      <= dir_d;
      step_upd_q <= step_upd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign phase_step = ps_q;
  assign step_upd   = step_upd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sweep_dir  = dir_q;

endmodule : nco_sweep_ctrl
`default_nettype wire
